blink_controller: RTL

- User-facing sequencer for the Blinky LED bank. Two asynchronous push-buttons (mode, pause) are synchronized, debounced and edge-detected.
- A mode FSM selects the LED pattern: off, slow blink, fast blink or chase. A per-mode tick divider advances the pattern.
- Sits between board button pins and LED pins. It is the only consumer of the two-flop synchronizer stages on those pins.

---
 rtl/blink_ctrl_pkg.sv | 37 +++
 rtl/blink_controller_button_debounce.sv | 73 +++++++
 rtl/blink_controller.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/blink_ctrl_pkg.sv
// Shared types and helpers for the Blinky LED bank sequencer:
// mode encoding, mode sequencing and divider sizing.
package blink_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_SLOW  = 2'd1,
    MODE_FAST  = 2'd2,
    MODE_CHASE = 2'd3
  } mode_t;

  localparam int SYNC_BITS = 2;

  function automatic int div_width(input int slow_div, input int fast_div);
    int max_div;
    if (slow_div > fast_div) begin
      max_div = slow_div;
    end else begin
      max_div = fast_div;
    end
    return $clog2(max_div);
  endfunction

  // Mode button order; CHASE wraps back to OFF.
  function automatic mode_t next_mode(input mode_t cur);
    mode_t nxt;
    case (cur)
      MODE_OFF:   nxt = MODE_SLOW;
      MODE_SLOW:  nxt = MODE_FAST;
      MODE_FAST:  nxt = MODE_CHASE;
      MODE_CHASE: nxt = MODE_OFF;
      default:    nxt = MODE_OFF;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/blink_controller_button_debounce.sv
// Button input path: two-flop synchronizer, debounce counter, accepted
// level and a one-cycle strobe on each accepted press (0->1).
module button_debounce
  import blink_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic in,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  logic [SYNC_BITS-1:0] sync_r;
  logic [CW-1:0]        cnt_r;
  logic [CW-1:0]        cnt_s;
  logic                 level_r;
  logic                 level_s;
  logic                 press_r;
  logic                 press_s;
  logic                 synced_s;

  assign synced_s = sync_r[SYNC_BITS-1];

  // Synchronizer shift register for the asynchronous pin.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_r <= {SYNC_BITS{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_BITS-2:0], in};
    end
  end

  // A candidate level must disagree with the accepted one for DEBOUNCE_CYCLES
  // consecutive cycles; any return to the accepted level restarts the count.
  always_comb begin
    cnt_s   = cnt_r;
    level_s = level_r;
    press_s = 1'b0;
    if (synced_s == level_r) begin
      cnt_s = CNT_ZERO;
    end else if (cnt_r == CNT_LAST) begin
      cnt_s   = CNT_ZERO;
      level_s = synced_s;
      press_s = synced_s;
    end else begin
      cnt_s = cnt_r + CNT_ONE;
    end
  end

  // Debounce state registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_r   <= CNT_ZERO;
      level_r <= 1'b0;
      press_r <= 1'b0;
    end else begin
      cnt_r   <= cnt_s;
      level_r <= level_s;
      press_r <= press_s;
    end
  end

  assign level = level_r;
  assign press = press_r;

endmodule

// File: rtl/blink_controller.sv
// Blinky LED bank sequencer: mode FSM, per-mode tick divider and LED pattern.
// Optional long-press-to-OFF on the pause button: BLINK_CTRL_LONG_PRESS_EN.
module blink_controller
  import blink_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 1_000_000,
  parameter int SLOW_DIV          = 50_000_000,
  parameter int FAST_DIV          = 12_500_000,
  parameter int NUM_LEDS          = 4,
  parameter int LONG_PRESS_CYCLES = 200_000_000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                btn_mode,
  input  logic                btn_pause,
  output logic [NUM_LEDS-1:0] led,
  output logic [1:0]          mode,
  output logic                paused
);

  localparam int DW = div_width(SLOW_DIV, FAST_DIV);
  localparam logic [DW-1:0]       SLOW_LAST = DW'(SLOW_DIV - 1);
  localparam logic [DW-1:0]       FAST_LAST = DW'(FAST_DIV - 1);
  localparam logic [DW-1:0]       DIV_ONE   = DW'(1);
  localparam logic [DW-1:0]       DIV_ZERO  = DW'(0);
  localparam logic [NUM_LEDS-1:0] LED_ONE   = NUM_LEDS'(1);
  localparam logic [NUM_LEDS-1:0] LED_ZERO  = {NUM_LEDS{1'b0}};
  localparam logic [NUM_LEDS-1:0] LED_ALL   = {NUM_LEDS{1'b1}};

  mode_t               mode_r;
  mode_t               mode_s;
  logic                paused_r;
  logic                paused_s;
  logic                phase_r;
  logic                phase_s;
  logic [DW-1:0]       div_r;
  logic [DW-1:0]       div_s;
  logic [DW-1:0]       div_last_s;
  logic [NUM_LEDS-1:0] led_r;
  logic [NUM_LEDS-1:0] led_s;
  logic                tick_s;
  logic                long_press_s;
  logic                mode_press_s;
  logic                pause_press_s;
  logic                pause_level_s;
  logic                mode_level_unused_s;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_mode_btn (
    .clock(clock),
    .reset(reset),
    .in   (btn_mode),
    .level(mode_level_unused_s),
    .press(mode_press_s)
  );

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_pause_btn (
    .clock(clock),
    .reset(reset),
    .in   (btn_pause),
    .level(pause_level_s),
    .press(pause_press_s)
  );

`ifdef BLINK_CTRL_LONG_PRESS_EN
  localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_PRESS_CYCLES);
  localparam logic [HW-1:0] HOLD_FIRE = HW'(LONG_PRESS_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
  localparam logic [HW-1:0] HOLD_ZERO = HW'(0);

  logic [HW-1:0] hold_r;

  // Hold timer saturates so the long press fires only once per hold.
  always_ff @(posedge clock) begin
    if (reset) begin
      hold_r <= HOLD_ZERO;
    end else if (!pause_level_s) begin
      hold_r <= HOLD_ZERO;
    end else if (hold_r != HOLD_MAX) begin
      hold_r <= hold_r + HOLD_ONE;
    end else begin
      hold_r <= hold_r;
    end
  end

  assign long_press_s = pause_level_s && (hold_r == HOLD_FIRE);
`else
  logic lp_unused_s;
  assign lp_unused_s  = pause_level_s & (LONG_PRESS_CYCLES > 32'sd0);
  assign long_press_s = 1'b0;
`endif

  assign div_last_s = (mode_r == MODE_SLOW) ? SLOW_LAST : FAST_LAST;
  assign tick_s     = (mode_r != MODE_OFF) && !paused_r && (div_r == div_last_s);

  // Next mode, pause flag, divider and LED pattern.
  always_comb begin
    mode_s   = mode_r;
    paused_s = paused_r;
    phase_s  = phase_r;
    div_s    = div_r;
    led_s    = led_r;
    if (long_press_s) begin
      mode_s   = MODE_OFF;
      paused_s = 1'b0;
      phase_s  = 1'b0;
      div_s    = DIV_ZERO;
      led_s    = LED_ZERO;
    end else begin
      if (mode_press_s) begin
        mode_s  = next_mode(mode_r);
        div_s   = DIV_ZERO;
        phase_s = 1'b0;
        if (mode_s == MODE_CHASE) begin
          led_s = LED_ONE;
        end else begin
          led_s = LED_ZERO;
        end
      end else if (mode_r == MODE_OFF) begin
        div_s = DIV_ZERO;
        led_s = LED_ZERO;
      end else if (paused_r) begin
        div_s = div_r;
        led_s = led_r;
      end else if (tick_s) begin
        div_s = DIV_ZERO;
        if (mode_r == MODE_CHASE) begin
          led_s = {led_r[NUM_LEDS-2:0], led_r[NUM_LEDS-1]};
        end else begin
          phase_s = ~phase_r;
          led_s   = phase_r ? LED_ZERO : LED_ALL;
        end
      end else begin
        div_s = div_r + DIV_ONE;
      end
      // The pause toggle takes effect after this cycle's tick, so a tick
      // coinciding with the strobe is still applied.
      if (pause_press_s) begin
        paused_s = ~paused_r;
      end else begin
        paused_s = paused_r;
      end
    end
  end

  // Sequencer state; led/mode/paused come straight from these registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      mode_r   <= MODE_OFF;
      paused_r <= 1'b0;
      phase_r  <= 1'b0;
      div_r    <= DIV_ZERO;
      led_r    <= LED_ZERO;
    end else begin
      mode_r   <= mode_s;
      paused_r <= paused_s;
      phase_r  <= phase_s;
      div_r    <= div_s;
      led_r    <= led_s;
    end
  end

  assign led    = led_r;
  assign mode   = mode_r;
  assign paused = paused_r;

endmodule
